// File: rtl/fir_pkg.sv
// Shared definitions for the FIR datapath helpers.
//   state_t : sample deinterleaver FSM encoding (S_EVEN / S_ODD / S_FULL)
//   DATA_W  : default sample width in bits
package fir_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        S_EVEN = 2'd0,   // no lane data held
        S_ODD  = 2'd1,   // lane 0 held, waiting for the odd sample
        S_FULL = 2'd2    // complete pair held, presented downstream
    } state_t;

endpackage

// File: rtl/demux1_2.sv
// 1:2 steering element, the inverse of a 2:1 mux.
// Ports:
//   i_data : sample to steer
//   i_en   : a sample is being written this cycle
//   i_sel  : 0 -> lane 0, 1 -> lane 1
//   o_we0  : write enable for lane 0
//   o_we1  : write enable for lane 1
//   o_data : sample routed to whichever lane is enabled
module demux1_2
    import fir_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic [W-1:0] i_data,
    input  logic         i_en,
    input  logic         i_sel,
    output logic         o_we0,
    output logic         o_we1,
    output logic [W-1:0] o_data
);

    assign o_we0  = i_en & ~i_sel;
    assign o_we1  = i_en &  i_sel;
    assign o_data = i_data;

endmodule

// File: rtl/sample_demux2.sv
// Two-lane polyphase deinterleaver. Alternating input samples are steered
// into lane 0 (even) and lane 1 (odd); each complete pair is presented on a
// registered valid/ready output.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   in_data/valid/ready  : serial sample stream
//   in_sync              : marks in_data as an even sample (phase realign)
//   out_data0/1          : even / odd sample of the held pair
//   out_valid/out_ready  : pair handshake
//   phase                : lane the next accepted sample goes to
//   err_drop / err_clr   : sticky "pending even sample discarded" flag, clear
//   pair_cnt             : wrapping count of pairs handed off
module sample_demux2
    import fir_pkg::*;
#(
    parameter int DATA_W = fir_pkg::DATA_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_sync,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data0,
    output logic [DATA_W-1:0] out_data1,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              phase,
    output logic              err_drop,
    input  logic              err_clr,
    output logic [CNT_W-1:0]  pair_cnt
);

    state_t            r_state;
    logic [DATA_W-1:0] r_lane0;
    logic [DATA_W-1:0] r_lane1;
    logic              r_out_valid;
    logic              r_err_drop;
    logic [CNT_W-1:0]  r_pair_cnt;

    logic              w_accept;
    logic              w_handoff;
    logic              w_sel;
    logic              w_we0;
    logic              w_we1;
    logic [DATA_W-1:0] w_data;
    logic              w_sync_drop;

    // While a pair is held, new input is only taken in the same cycle the
    // pair leaves, so lane data never changes under a valid output.
    assign in_ready  = !rst && ((r_state != S_FULL) || out_ready);
    assign w_accept  = in_valid & in_ready;
    assign w_handoff = r_out_valid & out_ready;

    // Only an unsynced sample arriving in S_ODD completes the pair; every
    // other accepted sample (including a sync realign) lands in lane 0.
    assign w_sel       = (r_state == S_ODD) && !in_sync;
    assign w_sync_drop = w_accept && (r_state == S_ODD) && in_sync;

    demux1_2 #(.W(DATA_W)) u_demux (
        .i_data (in_data),
        .i_en   (w_accept),
        .i_sel  (w_sel),
        .o_we0  (w_we0),
        .o_we1  (w_we1),
        .o_data (w_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_EVEN;
            r_lane0     <= '0;
            r_lane1     <= '0;
            r_out_valid <= 1'b0;
            r_err_drop  <= 1'b0;
            r_pair_cnt  <= '0;
        end else begin
            if (w_we0) r_lane0 <= w_data;
            if (w_we1) r_lane1 <= w_data;

            case (r_state)
                S_EVEN: begin
                    if (w_accept) r_state <= S_ODD;
                end
                S_ODD: begin
                    if (w_accept && !in_sync) begin
                        r_state     <= S_FULL;
                        r_out_valid <= 1'b1;
                    end
                end
                S_FULL: begin
                    if (w_handoff) begin
                        r_out_valid <= 1'b0;
                        r_state     <= w_accept ? S_ODD : S_EVEN;
                    end
                end
                default: begin
                    r_state     <= S_EVEN;
                    r_out_valid <= 1'b0;
                end
            endcase

            // A new drop in the same cycle as a clear wins.
            if (w_sync_drop)  r_err_drop <= 1'b1;
            else if (err_clr) r_err_drop <= 1'b0;

            if (w_handoff) r_pair_cnt <= r_pair_cnt + 1'b1;
        end
    end

    assign out_data0 = r_lane0;
    assign out_data1 = r_lane1;
    assign out_valid = r_out_valid;
    assign err_drop  = r_err_drop;
    assign pair_cnt  = r_pair_cnt;
    assign phase     = (r_state == S_ODD);

endmodule

// File: tb/tb_sample_demux2.sv
module tb_sample_demux2;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_sync;
    logic              in_ready;
    logic [DATA_W-1:0] out_data0;
    logic [DATA_W-1:0] out_data1;
    logic              out_valid;
    logic              out_ready;
    logic              phase;
    logic              err_drop;
    logic              err_clr;
    logic [CNT_W-1:0]  pair_cnt;

    int checks   = 0;
    int failures = 0;

    sample_demux2 #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_sync   (in_sync),
        .in_ready  (in_ready),
        .out_data0 (out_data0),
        .out_data1 (out_data1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .phase     (phase),
        .err_drop  (err_drop),
        .err_clr   (err_clr),
        .pair_cnt  (pair_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_data = '0; in_valid = 1'b0; in_sync = 1'b0;
        out_ready = 1'b0; err_clr = 1'b0;

        // ---- reset state
        step(); step();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_d0", out_data0, 0);
        chk("rst_d1", out_data1, 0);
        chk("rst_err", err_drop, 0);
        chk("rst_cnt", pair_cnt, 0);
        chk("rst_phase", phase, 0);

        // ---- streaming 0x11..0x44 with out_ready held high
        rst = 1'b0; out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h11;
        #1 chk("s_in_ready", in_ready, 1);
        step();
        chk("s1_phase", phase, 1);
        chk("s1_valid", out_valid, 0);
        in_data = 8'h22; step();
        chk("s2_valid", out_valid, 1);
        chk("s2_d0", out_data0, 8'h11);
        chk("s2_d1", out_data1, 8'h22);
        in_data = 8'h33; step();
        chk("s3_valid", out_valid, 0);
        chk("s3_cnt", pair_cnt, 1);
        chk("s3_d0", out_data0, 8'h33);
        in_data = 8'h44; step();
        chk("s4_valid", out_valid, 1);
        chk("s4_d0", out_data0, 8'h33);
        chk("s4_d1", out_data1, 8'h44);
        in_valid = 1'b0; step();
        chk("s5_valid", out_valid, 0);
        chk("s5_cnt", pair_cnt, 2);
        chk("s5_phase", phase, 0);

        // ---- backpressure: pair held for 5 clks
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h55; step();
        in_data = 8'h66; step();
        in_data = 8'h77;
        for (int i = 0; i < 5; i++) begin
            #1 chk($sformatf("bp%0d_in_ready", i), in_ready, 0);
            step();
            chk($sformatf("bp%0d_valid", i), out_valid, 1);
            chk($sformatf("bp%0d_d0", i), out_data0, 8'h55);
            chk($sformatf("bp%0d_d1", i), out_data1, 8'h66);
        end
        out_ready = 1'b1;
        #1 chk("bp_rel_in_ready", in_ready, 1);
        step();
        chk("bp_rel_valid", out_valid, 0);
        chk("bp_rel_cnt", pair_cnt, 3);
        chk("bp_rel_d0", out_data0, 8'h77);
        chk("bp_rel_phase", phase, 1);
        in_data = 8'h88; step();
        chk("bp_pair_d0", out_data0, 8'h77);
        chk("bp_pair_d1", out_data1, 8'h88);
        in_valid = 1'b0; step();
        chk("bp_cnt", pair_cnt, 4);

        // ---- sync realign drops the pending even sample
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h10; step();
        in_data = 8'h20; in_sync = 1'b1; step();
        chk("sy_err", err_drop, 1);
        chk("sy_phase", phase, 1);
        chk("sy_valid", out_valid, 0);
        in_data = 8'h30; in_sync = 1'b0; step();
        chk("sy_valid2", out_valid, 1);
        chk("sy_d0", out_data0, 8'h20);
        chk("sy_d1", out_data1, 8'h30);
        in_valid = 1'b0; out_ready = 1'b1; step();
        chk("sy_cnt", pair_cnt, 5);

        // ---- set beats clear, clear alone clears
        in_valid = 1'b1; in_data = 8'h40; step();
        in_data = 8'h41; in_sync = 1'b1; err_clr = 1'b1; step();
        chk("clr_set_err", err_drop, 1);
        in_valid = 1'b0; in_sync = 1'b0; step();
        chk("clr_err", err_drop, 0);
        err_clr = 1'b0;
        in_valid = 1'b1; in_data = 8'h42; step();
        chk("pre_rst_valid", out_valid, 1);
        chk("pre_rst_d0", out_data0, 8'h41);

        // ---- reset while S_FULL
        rst = 1'b1; in_valid = 1'b0; step();
        rst = 1'b0;
        chk("mr_valid", out_valid, 0);
        chk("mr_d0", out_data0, 0);
        chk("mr_d1", out_data1, 0);
        chk("mr_cnt", pair_cnt, 0);
        chk("mr_phase", phase, 0);
        in_valid = 1'b1; in_data = 8'h99; step();
        chk("mr_first_phase", phase, 1);
        chk("mr_first_d0", out_data0, 8'h99);
        chk("mr_first_valid", out_valid, 0);
        in_data = 8'h9A; step();
        in_valid = 1'b0; step();
        chk("mr_cnt1", pair_cnt, 1);

        // ---- 17 back-to-back pairs, 4-bit counter wraps
        rst = 1'b1; step();
        rst = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 34; k++) begin
            in_data = 8'(k);
            step();
            chk($sformatf("bb%0d_valid", k), out_valid, (k % 2 == 1) ? 1 : 0);
            if (k % 2 == 1) begin
                chk($sformatf("bb%0d_d0", k), out_data0, k - 1);
                chk($sformatf("bb%0d_d1", k), out_data1, k);
            end
            if (k == 30) chk("bb_cnt15", pair_cnt, 15);
            if (k == 32) chk("bb_cnt_wrap", pair_cnt, 0);
        end
        in_valid = 1'b0; step();
        chk("bb_cnt_end", pair_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sample_demux2.md
Name: sample_demux2

Overview:
- Two-lane polyphase deinterleaver for the FIR datapath. It is the splitting counterpart of the 2:1 sample mux.
- Accepts one serial sample stream with valid/ready and steers alternating samples into lane 0 (even) and lane 1 (odd).
- Presents each even/odd pair together on a registered output with valid/ready, so the two polyphase sub-filters each consume one sample per pair.

Parameters:
- DATA_W, 8, sample width in bits.
- CNT_W, 16, width of the emitted-pair counter.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  DATA_W  incoming sample.
- in_valid  input  1  in_data is valid this cycle.
- in_sync  input  1  qualifies in_data as an even (lane 0) sample; phase realign.
- in_ready  output  1  block accepts in_data this cycle.
- out_data0  output  DATA_W  lane 0 (even) sample of the pair.
- out_data1  output  DATA_W  lane 1 (odd) sample of the pair.
- out_valid  output  1  pair valid.
- out_ready  input  1  downstream accepts the pair.
- phase  output  1  lane the next accepted sample goes to (0 = even).
- err_drop  output  1  sticky flag: a pending even sample was discarded by in_sync.
- err_clr  input  1  clears err_drop.
- pair_cnt  output  CNT_W  number of pairs handed off (out_valid & out_ready).

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): state=S_EVEN; out_data0=0, out_data1=0, out_valid=0, err_drop=0, pair_cnt=0, phase=0. in_ready=0 while rst is high.
- Accept = in_valid & in_ready. Handoff = out_valid & out_ready.
- in_ready (combinational) = !rst & (state!=S_FULL | out_ready).
- States:
  - S_EVEN: no lane data held. On accept: capture in_data into lane 0 → S_ODD.
  - S_ODD: lane 0 held. On accept with in_sync=0: capture into lane 1 → S_FULL, out_valid=1 next cycle. On accept with in_sync=1: overwrite lane 0, set err_drop, stay S_ODD.
  - S_FULL: pair held, out_valid=1, out_data0/1 stable until handoff. On handoff without accept → S_EVEN, out_valid=0. On handoff with accept in the same cycle: new sample goes into lane 0 → S_ODD, out_valid=0. There is no accept without handoff, since in_ready=0.
- in_sync in S_EVEN or on the S_FULL→S_ODD path is a normal even sample with no error. in_sync without in_valid is ignored.
- Latency: out_valid rises on the clk edge that accepts the odd sample, i.e. it is visible the cycle after that sample is presented.
- Throughput: 1 sample/clk sustained when out_ready is held at 1, i.e. one pair every 2 clks.
- phase = (state==S_ODD).
- Lane data written while out_valid=1 is impossible by construction. out_data0/1 only change on a capture edge.
- pair_cnt increments on handoff and wraps from 2^CNT_W-1 to 0.
- err_drop: set has priority over err_clr in the same cycle. err_clr alone clears it on the next edge.
- Reset mid-pair (rst in S_ODD or S_FULL): pending data discarded, outputs return to reset values, no handoff counted.

Decomposition:
- Shared package fir_pkg: state encoding constants S_EVEN=2'd0, S_ODD=2'd1, S_FULL=2'd2, plus the default DATA_W.
- One natural sub-module, demux1_2: combinational steering of in_data to a lane-0/lane-1 write enable from a select bit. It is the inverse of the 2:1 mux.
- The FSM, counter and error flag stay in sample_demux2.

Test Plan:
- Reset then stream 0x11,0x22,0x33,0x44 with in_valid=1 and out_ready=1 held → pairs (0x11,0x22) then (0x33,0x44); out_valid high for 1 clk every 2 clks; pair_cnt=2.
- Pair held with out_ready=0 for 5 clks while in_valid=1 → in_ready=0 and out_data0/1 unchanged throughout. Raising out_ready → handoff, and the next sample is captured into lane 0 in the same cycle.
- Send 0x10 (S_ODD), then 0x20 with in_sync=1, then 0x30 → err_drop=1; output pair is (0x20,0x30); 0x10 never appears.
- err_drop=1 with err_clr=1 and a new sync-drop in the same cycle → err_drop stays 1. err_clr alone next cycle → 0.
- Assert rst for 1 clk while in S_FULL → out_valid=0, out_data0/1=0, pair_cnt=0, phase=0. The first sample after reset lands in lane 0.
- CNT_W=4 with 17 back-to-back pairs → pair_cnt reaches 15, wraps to 0, ends at 1.
